// File: rtl/md_sched.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO pair.
// Runs MULT/DIV for a fixed latency and stalls dependent HI/LO users in E.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CP0_jump,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic               accept;
  logic               div_ovf;
  logic [31:0]        div_b;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;

  // Divisor of 1 stands in for zero (result discarded anyway) and for the
  // INT_MIN / -1 overflow, where a/1 = INT_MIN, rem 0 is exactly the answer.
  always_comb begin
    div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    div_b   = ((b_q == 32'd0) || div_ovf) ? 32'd1 : b_q;
    prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u  = {32'd0, a_q} * {32'd0, b_q};
    quot_s  = $signed(a_q) / $signed(div_b);
    rem_s   = $signed(a_q) % $signed(div_b);
    quot_u  = a_q / div_b;
    rem_u   = a_q % div_b;
  end

  assign accept = start && !CP0_jump && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              op_d    = op[1:0];
              a_d     = rs_data;
              b_d     = rt_data;
              cnt_d   = op[1] ? DIV_LOAD : MULT_LOAD;
              state_d = RUN;
            end
            3'd4:    hi_d = rs_data;
            3'd5:    lo_d = rs_data;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
          case (op_q)
            2'd0: {hi_d, lo_d} = prod_s;
            2'd1: {hi_d, lo_d} = prod_u;
            2'd2: if (b_q != 32'd0) begin
              hi_d = rem_s;
              lo_d = quot_s;
            end
            default: if (b_q != 32'd0) begin
              hi_d = rem_u;
              lo_d = quot_u;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign stall  = md_use && (busy || (start && !CP0_jump && !op[2]));
  assign done   = done_q;
  assign HI_out = hi_q;
  assign LO_out = lo_q;

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide sequencer that owns the HI/LO pair feeding the M-stage pipeline register.
- Accepts E-stage MULT/MULTU/DIV/DIVU/MTHI/MTLO commands and runs multiply or divide for a fixed latency.
- Drives busy and an E-stage stall for dependent HI/LO instructions.
- Suppresses a command issued in the same cycle as a CP0 exception/interrupt jump.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low; reset=0 clears all state immediately.
- CP0_jump  input  1  exception/interrupt redirect this cycle; kills same-cycle start.
- start  input  1  E-stage command valid.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (no-op).
- rs_data  input  32  operand A / MTHI, MTLO source.
- rt_data  input  32  operand B.
- md_use  input  1  E-stage instruction touches HI/LO (any of the six ops, MFHI or MFLO).
- busy  output  1  operation in flight.
- stall  output  1  freeze F/D/E.
- done  output  1  one-cycle pulse when HI/LO are written by MULT/DIV.
- HI_out  output  32  HI register.
- LO_out  output  32  LO register.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: HI_out=0, LO_out=0, busy=0, done=0, state=IDLE, cnt=0.
- States: IDLE, RUN. Internal registers: 4-bit cnt, latched operands, latched op.
- Accept condition: start=1, CP0_jump=0, state=IDLE. All accepted commands are registered on the edge.
- Accept rules:
  - MULT/MULTU/DIV/DIVU: latch op, rs_data and rt_data; go to RUN; cnt = N-1, where N is MULT_CYCLES or DIV_CYCLES.
  - MTHI/MTLO: write HI or LO on the same edge; stay IDLE; busy stays 0.
  - Reserved op: ignored.
- RUN: busy=1. Each cycle, if cnt≠0 then cnt decrements. On the edge where cnt=0:
  - write HI/LO;
  - pulse done for the following cycle;
  - return to IDLE.
- Latency: busy is high for exactly N cycles after the accepting edge. New HI/LO values are visible on HI_out/LO_out in the cycle busy falls.
- stall = md_use & (busy | (start & ~CP0_jump & op∈{0..3})). Combinational.
- start while RUN: ignored. Stall prevents this legally; the bench checks that state is unaffected.
- CP0_jump with start: command dropped, HI/LO unchanged.
- CP0_jump during RUN: no effect; the in-flight operation completes.
- Arithmetic:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder, which takes the dividend's sign.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (rt=0): HI/LO unchanged; busy/done timing still normal.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Reset asserted mid-RUN: immediate return to IDLE with reset values; in-flight result discarded.

Test Plan:
- Reset low then high; start MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, done pulses once.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rt=0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO -> busy 10 cycles, done pulses, HI=0x11, LO=0x22 retained.
- start MULT with CP0_jump=1 -> busy stays 0, stall=0, HI/LO unchanged.
- MULT in flight with md_use=1 (MFLO) -> stall=1 every busy cycle and 0 the cycle busy falls. Pulling reset low at busy cycle 3 forces busy=0, HI=LO=0 asynchronously.
